// File: rtl/keypad_pkg.sv
// Shared types and key-code remapping for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } scan_state_e;

  // Team 4x4 keypad layout: entry [i] is the logical code of physical index i.
  localparam logic [15:0][3:0] REMAP_TBL = {
    4'd15, 4'd0,  4'd13, 4'd12,
    4'd7,  4'd8,  4'd9,  4'd11,
    4'd4,  4'd5,  4'd6,  4'd10,
    4'd1,  4'd2,  4'd3,  4'd14
  };

  // Physical index (col*ROWS + row) to logical key code.
  function automatic int unsigned remap_code(input int unsigned index, input bit remap);
    if (remap) begin
      return int'(REMAP_TBL[index[3:0]]);
    end
    return index;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key delivery channel: valid/ready key register plus press status.
interface keypad_scanner_if #(
  parameter int CW = 4
);
  logic [CW-1:0] key_code;
  logic          key_valid;
  logic          key_ready;
  logic          key_pressed;
  logic          overrun;

  modport master (
    output key_code,
    output key_valid,
    output key_pressed,
    output overrun,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_pressed,
    input  overrun,
    output key_ready
  );
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchroniser; resets to all ones so idle (pulled-up) rows read as released.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back capture stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column drive, row sensing, press/release debounce,
// key-code remap and a valid/ready output register.
//
// state       | meaning
// ST_SCAN     | idle, stepping one column per dwell looking for a low row
// ST_DEBOUNCE | candidate key seen, column held, counting identical hit ticks
// ST_PRESSED  | key accepted, waiting for DEBOUNCE all-high ticks to release
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 8,
  parameter int REMAP    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_out,
  keypad_scanner_if.master key_if
);

  localparam int CW   = $clog2(ROWS * COLS);
  localparam int DIVW = $clog2(SCAN_DIV);
  localparam int DBW  = $clog2(DEBOUNCE + 1);
  localparam int COLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROWW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ROWS_U = ROWS;

  generate
    if (REMAP != 0 && (ROWS != 4 || COLS != 4)) begin : g_bad_remap
      $error("keypad_scanner: REMAP=1 needs a 4x4 keypad");
    end
  endgenerate

  logic [ROWS-1:0] rs;

  sync_2ff #(.WIDTH(ROWS)) u_row_sync (
    .clk (clk),
    .rst (reset),
    .d   (row_in),
    .q   (rs)
  );

  scan_state_e     state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [COLW-1:0] col_q, col_d, col_adv;
  logic [ROWW-1:0] row_q, row_d, low_row, acc_row;
  logic [DBW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [DBW-1:0]  rel_q, rel_d, rel_inc;
  logic [COLS-1:0] col_out_q;
  logic [CW-1:0]   key_code_q, key_code_d, acc_code;
  logic            key_valid_q, key_valid_d;
  logic            overrun_q, overrun_d;
  logic            tick, hit, accept;
  int unsigned     phys_idx;

  assign tick    = (div_q == DIVW'(SCAN_DIV - 1));
  assign hit     = ~&rs;
  assign col_adv = (col_q == COLW'(COLS - 1)) ? '0 : col_q + 1'b1;
  assign cnt_inc = cnt_q + 1'b1;
  assign rel_inc = rel_q + 1'b1;

  // Dwell divider free-runs in every state.
  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Lowest-numbered low row wins when several rows are pulled down.
  always_comb begin
    low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rs[i]) low_row = ROWW'(i);
    end
  end

  assign phys_idx = 32'(col_q) * ROWS_U + 32'(acc_row);
  assign acc_code = CW'(remap_code(phys_idx, REMAP != 0));

  // Scan/debounce/release sequencing; every decision is taken on a tick.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    accept  = 1'b0;
    acc_row = row_q;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (hit) begin
            row_d = low_row;
            cnt_d = DBW'(1);
            if (DEBOUNCE == 1) begin
              accept  = 1'b1;
              acc_row = low_row;
              rel_d   = '0;
              state_d = ST_PRESSED;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else begin
            col_d = col_adv;
          end
        end
        ST_DEBOUNCE: begin
          if (hit && (low_row == row_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DBW'(DEBOUNCE)) begin
              accept  = 1'b1;
              rel_d   = '0;
              state_d = ST_PRESSED;
            end
          end else begin
            // Bounce: give up on this key but re-examine the same column.
            cnt_d   = '0;
            state_d = ST_SCAN;
          end
        end
        ST_PRESSED: begin
          if (!hit) begin
            rel_d = rel_inc;
            if (rel_inc == DBW'(DEBOUNCE)) begin
              rel_d   = '0;
              cnt_d   = '0;
              col_d   = col_adv;
              state_d = ST_SCAN;
            end
          end else begin
            rel_d = '0;
          end
        end
        default: begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          rel_d   = '0;
        end
      endcase
    end
  end

  // Output register: load on accept unless an unconsumed key would be overwritten.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = 1'b0;
    if (key_valid_q && key_if.key_ready) key_valid_d = 1'b0;
    if (accept) begin
      if (!key_valid_q || key_if.key_ready) begin
        key_code_d  = acc_code;
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State, counters, column drive and key register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SCAN;
      div_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      cnt_q       <= '0;
      rel_q       <= '0;
      col_out_q   <= ~COLS'(1);
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      col_out_q   <= ~(COLS'(1) << col_d);
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign col_out            = col_out_q;
  assign key_if.key_code    = key_code_q;
  assign key_if.key_valid   = key_valid_q;
  assign key_if.key_pressed = (state_q == ST_PRESSED);
  assign key_if.overrun     = overrun_q;

endmodule
